seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised multi-cycle ALU for the MIPS datapath, replacing the single-bit-control add/subtract ALU. Adds logic ops, signed set-less-than, overflow, and iterative unsigned multiply and divide with a start/busy/done handshake. The control unit stalls the PC while `busy` is high. Single-cycle ops return results one clock after `start`.

## Interface
- `WIDTH`, 32, operand and result width (≥ 4).
- `clk`  in  1  rising-edge clock; the block's only clock.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  request; sampled only when idle.
- `op`  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT (signed), 5 MULTU, 6 DIVU, 7 reserved.
- `A`, `B`  in  WIDTH  operands, captured when `start` is accepted.
- `busy`  out  1  multi-cycle op in progress.
- `done`  out  1  one-cycle pulse when results are valid.
- `result_lo`  out  WIDTH  result, product low half, or quotient.
- `result_hi`  out  WIDTH  product high half or remainder; 0 for other ops.
- `c_flag`  out  1  carry (ADD) or borrow (SUB); 0 otherwise.
- `v_flag`  out  1  signed overflow (ADD/SUB); 0 otherwise.
- `zero_flag`  out  1  `result_lo == 0`; registered with the results.
- `div_by_zero`  out  1  DIVU with B = 0.

## Operation
- FSM states: IDLE, MUL, DIV.
- In IDLE, `start=1` accepts the request and latches `op`, `A`, and `B`.
  - ADD/SUB/AND/OR/SLT/reserved: results registered at the same edge; stays IDLE.
  - MULTU: go to MUL.
  - DIVU with B ≠ 0: go to DIV.
  - DIVU with B = 0: finishes in one cycle: `result_lo` all ones, `result_hi = A`, `div_by_zero=1`.
- ADD: `{c_flag, result_lo} = A + B` in WIDTH+1 bits. `v_flag` = operand signs equal and result sign differs.
- SUB: `{c_flag, result_lo} = A − B` in WIDTH+1 bits, so `c_flag=1` iff A < B unsigned. `v_flag` = operand signs differ and result sign differs from A.
- AND / OR: bitwise.
- SLT: `result_lo` = 1 if A < B signed, else 0.
- Reserved: all results and flags are 0.
- MUL: shift-add, one multiplier bit per cycle, WIDTH iterations. Product is 2·WIDTH bits: `{result_hi, result_lo}`.
- DIV: restoring division, one quotient bit per cycle, WIDTH iterations.
- `start` is ignored while `busy=1`. No queueing.
- Outputs hold their last values until the next `done`.
- `div_by_zero` is cleared on every accepted op that is not a divide-by-zero.
- Iteration counter: log2(WIDTH)+1 bits, loaded with WIDTH−1, counts down; the last iteration is at 0.

## Timing
- Reset (`rst=1` at an edge): state IDLE. `busy`, `done`, `result_lo`, `result_hi`, `c_flag`, `v_flag`, `div_by_zero` all 0; `zero_flag` is 1.
- Reset during MUL/DIV aborts the operation; no `done` is produced.
- Single-cycle ops: `start` at edge N, then `done=1` and results valid after edge N, for one cycle. `busy` stays 0.
- MULTU / DIVU: `start` at edge N.
  - `busy=1` after edge N through edge N+WIDTH.
  - At edge N+WIDTH: `busy` falls, `done=1`, results valid.
  - Latency is WIDTH+1 cycles from request to `done`; 33 cycles when WIDTH=32.
- Back-to-back: `start` may be asserted in the `done` cycle and is accepted, because the FSM is already IDLE.
- Operands may change after acceptance without affecting the result.

## Test plan
- Reset, then idle: `zero_flag=1`, all other outputs 0. Pulse `rst` during MULTU at cycle 10: `busy` goes to 0 and no `done` appears.
- ADD A=0xFFFFFFFF, B=1 → `result_lo=0`, `c_flag=1`, `zero_flag=1`, `v_flag=0`. ADD 0x7FFFFFFF+1 → 0x80000000, `v_flag=1`.
- SUB 3−5 → `result_lo=0xFFFFFFFE`, `c_flag=1`. SLT A=0xFFFFFFFF, B=1 → 1. AND/OR 0xF0F0,0x0FF0 → 0x00F0 / 0xFFF0. Op 7 → all results 0.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `result_hi=0xFFFFFFFE`, `result_lo=0x00000001`. `done` exactly 33 cycles after `start`; `start` pulsed mid-op is ignored.
- DIVU 100 / 7 → `result_lo=14`, `result_hi=2`. DIVU 5 / 0 → one-cycle `done`, `result_lo=0xFFFFFFFF`, `result_hi=5`, `div_by_zero=1`.
- Back-to-back: MULTU, then ADD issued in the MULTU `done` cycle → ADD `done` one cycle later. Randomised ops against a reference model at WIDTH=8 and WIDTH=32.

Source files
------------

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle add/sub/logic/slt, plus iterative unsigned
// shift-add multiply and restoring divide behind a start/busy/done handshake.
module seq_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             c_flag,
  output logic             v_flag,
  output logic             zero_flag,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_AND   = 3'd2;
  localparam logic [2:0] OP_OR    = 3'd3;
  localparam logic [2:0] OP_SLT   = 3'd4;
  localparam logic [2:0] OP_MULTU = 3'd5;
  localparam logic [2:0] OP_DIVU  = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t state, state_next;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] work_hi;
  logic [WIDTH-1:0] work_lo;

  logic             accept;
  logic             is_mul, is_div;
  logic [WIDTH:0]   add_full, sub_full;
  logic [WIDTH-1:0] sc_lo, sc_hi;
  logic             sc_c, sc_v, sc_dbz;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_next, mul_lo_next;
  logic [WIDTH:0]   div_shift;
  logic             div_ok;
  logic [WIDTH-1:0] rem_next, q_next;

  assign busy     = (state != S_IDLE);
  assign accept   = start && (state == S_IDLE);
  assign is_mul   = (op == OP_MULTU);
  assign is_div   = (op == OP_DIVU) && (B != '0);
  assign add_full = {1'b0, A} + {1'b0, B};
  assign sub_full = {1'b0, A} - {1'b0, B};

  always_comb begin
    sc_lo  = '0;
    sc_hi  = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    sc_dbz = 1'b0;
    case (op)
      OP_ADD: begin
        {sc_c, sc_lo} = add_full;
        sc_v = (A[WIDTH-1] == B[WIDTH-1]) && (add_full[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        {sc_c, sc_lo} = sub_full;
        sc_v = (A[WIDTH-1] != B[WIDTH-1]) && (sub_full[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND: sc_lo = A & B;
      OP_OR:  sc_lo = A | B;
      OP_SLT: sc_lo = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_DIVU: begin
        // only reaches the result path when B == 0
        sc_lo  = '1;
        sc_hi  = A;
        sc_dbz = 1'b1;
      end
      default: ;
    endcase
  end

  // Multiply: {work_hi, work_lo} holds partial product above the unconsumed multiplier bits.
  assign mul_sum     = {1'b0, work_hi} + {1'b0, (work_lo[0] ? b_reg : {WIDTH{1'b0}})};
  assign mul_hi_next = mul_sum[WIDTH:1];
  assign mul_lo_next = {mul_sum[0], work_lo[WIDTH-1:1]};

  // Divide: work_hi is the remainder, work_lo shifts dividend out and quotient in.
  assign div_shift = {work_hi, work_lo[WIDTH-1]};
  assign div_ok    = (div_shift >= {1'b0, b_reg});
  assign rem_next  = div_ok ? WIDTH'(div_shift - {1'b0, b_reg}) : div_shift[WIDTH-1:0];
  assign q_next    = {work_lo[WIDTH-2:0], div_ok};

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept && is_mul)      state_next = S_MUL;
        else if (accept && is_div) state_next = S_DIV;
      end
      S_MUL, S_DIV: if (cnt == '0) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done        <= 1'b0;
      result_lo   <= '0;
      result_hi   <= '0;
      c_flag      <= 1'b0;
      v_flag      <= 1'b0;
      zero_flag   <= 1'b1;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      b_reg       <= '0;
      work_hi     <= '0;
      work_lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            div_by_zero <= 1'b0;
            if (is_mul || is_div) begin
              work_hi <= '0;
              work_lo <= A;
              b_reg   <= B;
              cnt     <= CW'(WIDTH - 1);
            end else begin
              result_lo   <= sc_lo;
              result_hi   <= sc_hi;
              c_flag      <= sc_c;
              v_flag      <= sc_v;
              zero_flag   <= (sc_lo == '0);
              div_by_zero <= sc_dbz;
              done        <= 1'b1;
            end
          end
        end
        S_MUL: begin
          work_hi <= mul_hi_next;
          work_lo <= mul_lo_next;
          cnt     <= cnt - 1'b1;
          if (cnt == '0) begin
            result_lo <= mul_lo_next;
            result_hi <= mul_hi_next;
            c_flag    <= 1'b0;
            v_flag    <= 1'b0;
            zero_flag <= (mul_lo_next == '0);
            done      <= 1'b1;
          end
        end
        S_DIV: begin
          work_hi <= rem_next;
          work_lo <= q_next;
          cnt     <= cnt - 1'b1;
          if (cnt == '0) begin
            result_lo <= q_next;
            result_hi <= rem_next;
            c_flag    <= 1'b0;
            v_flag    <= 1'b0;
            zero_flag <= (q_next == '0);
            done      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector and randomised bench for seq_alu at WIDTH=32 and WIDTH=8.
module tb_seq_alu;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [31:0] lo, hi;
    logic        c, v, z, dz;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start32 = 1'b0, start8 = 1'b0;
  logic [2:0]  op32 = '0, op8 = '0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy32, done32, c32, v32, z32, dz32;
  logic        busy8, done8, c8, v8, z8, dz8;
  logic [31:0] lo32, hi32;
  logic [7:0]  lo8, hi8;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .start(start32), .op(op32), .A(a32), .B(b32),
    .busy(busy32), .done(done32), .result_lo(lo32), .result_hi(hi32),
    .c_flag(c32), .v_flag(v32), .zero_flag(z32), .div_by_zero(dz32)
  );

  seq_alu #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .result_lo(lo8), .result_hi(hi8),
    .c_flag(c8), .v_flag(v8), .zero_flag(z8), .div_by_zero(dz8)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Independent arithmetic reference, computed in 64-bit integers.
  function automatic vec_t model(input int w, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
    vec_t r;
    longint unsigned mask, am, bm, s;
    longint sa, sb;
    mask = (64'd1 << w) - 1;
    am = a & mask;
    bm = b & mask;
    sa = (am[w-1]) ? longint'(am) - longint'(64'd1 << w) : longint'(am);
    sb = (bm[w-1]) ? longint'(bm) - longint'(64'd1 << w) : longint'(bm);
    r.op = op; r.a = 32'(am); r.b = 32'(bm);
    r.lo = '0; r.hi = '0; r.c = 0; r.v = 0; r.dz = 0;
    case (op)
      3'd0: begin
        s = am + bm;
        r.lo = 32'(s & mask);
        r.c  = s[w];
        r.v  = (am[w-1] == bm[w-1]) && (s[w-1] != am[w-1]);
      end
      3'd1: begin
        s = (am - bm) & mask;
        r.lo = 32'(s);
        r.c  = (am < bm);
        r.v  = (am[w-1] != bm[w-1]) && (s[w-1] != am[w-1]);
      end
      3'd2: r.lo = 32'(am & bm);
      3'd3: r.lo = 32'(am | bm);
      3'd4: r.lo = (sa < sb) ? 32'd1 : 32'd0;
      3'd5: begin
        s = am * bm;
        r.lo = 32'(s & mask);
        r.hi = 32'((s >> w) & mask);
      end
      3'd6: begin
        if (bm == 0) begin
          r.lo = 32'(mask); r.hi = 32'(am); r.dz = 1;
        end else begin
          r.lo = 32'(am / bm); r.hi = 32'(am % bm);
        end
      end
      default: ;
    endcase
    r.z = (r.lo == 0);
    return r;
  endfunction

  function automatic int exp_lat(input int w, input logic [2:0] op, input logic [31:0] b);
    return (op == 3'd5 || (op == 3'd6 && b != 0)) ? w : 0;
  endfunction

  // Drive one request, scramble operands after acceptance, wait (bounded) for done.
  task automatic apply(input int w, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int lat);
    if (w == 32) begin op32 = op; a32 = a; b32 = b; start32 = 1'b1; end
    else begin op8 = op; a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1; end
    @(posedge clk); #1;
    start32 = 1'b0; start8 = 1'b0;
    a32 = ~a32; b32 = $urandom; a8 = ~a8; b8 = 8'($urandom);
    lat = 0;
    while (!(w == 32 ? done32 : done8) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_out(input int w, input string tag, input vec_t e, input int lat);
    if (w == 32) begin
      chk({tag, " lo"}, 64'(lo32), 64'(e.lo));
      chk({tag, " hi"}, 64'(hi32), 64'(e.hi));
      chk({tag, " c"}, 64'(c32), 64'(e.c));
      chk({tag, " v"}, 64'(v32), 64'(e.v));
      chk({tag, " zero"}, 64'(z32), 64'(e.z));
      chk({tag, " dbz"}, 64'(dz32), 64'(e.dz));
      chk({tag, " busy"}, 64'(busy32), 64'd0);
    end else begin
      chk({tag, " lo"}, 64'(lo8), 64'(e.lo));
      chk({tag, " hi"}, 64'(hi8), 64'(e.hi));
      chk({tag, " c"}, 64'(c8), 64'(e.c));
      chk({tag, " v"}, 64'(v8), 64'(e.v));
      chk({tag, " zero"}, 64'(z8), 64'(e.z));
      chk({tag, " dbz"}, 64'(dz8), 64'(e.dz));
      chk({tag, " busy"}, 64'(busy8), 64'd0);
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat(w, e.op, e.b)));
  endtask

  vec_t tbl[13];
  vec_t e;
  int   lat;
  int   seen;

  initial begin
    //           op    A             B             lo            hi            c  v  z  dz
    tbl[0]  = '{3'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0,        1, 0, 1, 0};
    tbl[1]  = '{3'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0,        0, 1, 0, 0};
    tbl[2]  = '{3'd1, 32'd3,        32'd5,        32'hFFFFFFFE, 32'h0,        1, 0, 0, 0};
    tbl[3]  = '{3'd4, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0,        0, 0, 0, 0};
    tbl[4]  = '{3'd2, 32'h0000F0F0, 32'h00000FF0, 32'h000000F0, 32'h0,        0, 0, 0, 0};
    tbl[5]  = '{3'd3, 32'h0000F0F0, 32'h00000FF0, 32'h0000FFF0, 32'h0,        0, 0, 0, 0};
    tbl[6]  = '{3'd7, 32'h00001234, 32'h00005678, 32'h00000000, 32'h0,        0, 0, 1, 0};
    tbl[7]  = '{3'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 0, 0, 0, 0};
    tbl[8]  = '{3'd6, 32'd100,      32'd7,        32'd14,       32'd2,        0, 0, 0, 0};
    tbl[9]  = '{3'd6, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        0, 0, 0, 1};
    tbl[10] = '{3'd1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0,        0, 1, 0, 0};
    tbl[11] = '{3'd4, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'h0,        0, 0, 1, 0};
    tbl[12] = '{3'd5, 32'h00000000, 32'h00000005, 32'h00000000, 32'h0,        0, 0, 1, 0};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("reset busy", 64'(busy32), 64'd0);
    chk("reset done", 64'(done32), 64'd0);
    chk("reset lo", 64'(lo32), 64'd0);
    chk("reset hi", 64'(hi32), 64'd0);
    chk("reset c", 64'(c32), 64'd0);
    chk("reset v", 64'(v32), 64'd0);
    chk("reset zero", 64'(z32), 64'd1);
    chk("reset dbz", 64'(dz32), 64'd0);

    for (int i = 0; i < 13; i++) begin
      apply(32, tbl[i].op, tbl[i].a, tbl[i].b, lat);
      check_out(32, $sformatf("vec%0d", i), tbl[i], lat);
    end

    // start pulsed mid-multiply must be ignored
    op32 = 3'd5; a32 = 32'hFFFFFFFF; b32 = 32'hFFFFFFFF; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0; lat = 0;
    repeat (5) begin @(posedge clk); #1; lat++; end
    op32 = 3'd0; a32 = 32'd1; b32 = 32'd1; start32 = 1'b1;
    @(posedge clk); #1;
    lat++; start32 = 1'b0;
    chk("midop busy", 64'(busy32), 64'd1);
    chk("midop done", 64'(done32), 64'd0);
    while (!done32 && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("midop latency", 64'(lat), 64'd32);
    chk("midop lo", 64'(lo32), 64'h1);
    chk("midop hi", 64'(hi32), 64'hFFFFFFFE);

    // ADD issued in the MULTU done cycle
    apply(32, 3'd5, 32'd3, 32'd4, lat);
    chk("b2b mul lo", 64'(lo32), 64'd12);
    chk("b2b mul latency", 64'(lat), 64'd32);
    apply(32, 3'd0, 32'd2, 32'd3, lat);
    chk("b2b add lo", 64'(lo32), 64'd5);
    chk("b2b add latency", 64'(lat), 64'd0);

    // reset aborts a multiply
    op32 = 3'd5; a32 = 32'h12345678; b32 = 32'h9ABCDEF0; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort busy", 64'(busy32), 64'd0);
    chk("abort done", 64'(done32), 64'd0);
    chk("abort lo", 64'(lo32), 64'd0);
    chk("abort zero", 64'(z32), 64'd1);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (done32 || busy32) seen++; end
    chk("abort no done", 64'(seen), 64'd0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      e = model(32, rop, ra, rb);
      apply(32, rop, ra, rb, lat);
      check_out(32, $sformatf("rand32_%0d op%0d", i, rop), e, lat);
    end

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom & 32'hFF;
      rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom & 32'hFF);
      e = model(8, rop, ra, rb);
      apply(8, rop, ra, rb, lat);
      check_out(8, $sformatf("rand8_%0d op%0d", i, rop), e, lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
